// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD event counter with a time-multiplexed digit scanner.
// It presents one digit at a time on data, selected by a one-hot digit_en, and blanks leading zeros with 4'hF.
module bcd_scan_counter #(
  parameter int NDIGITS  = 4,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK_LZ = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inc,
  input  logic                   clr,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   load_value,
  output logic [4*NDIGITS-1:0]   count,
  output logic                   overflow,
  output logic [3:0]             data,
  output logic [NDIGITS-1:0]     digit_en
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);

  logic [4*NDIGITS-1:0] count_reg, count_next;
  logic                 overflow_reg, overflow_next;
  logic [PW-1:0]        prescale_reg;
  logic [IW-1:0]        index_reg, index_next;
  logic [NDIGITS-1:0]   digit_en_reg;
  logic [NDIGITS:0]     carry;
  logic [4*NDIGITS-1:0] inc_value, load_clean;
  logic [NDIGITS-1:0]   upper_zero;
  logic [3:0]           digit [NDIGITS];
  logic                 blank;

  // carry[i] means every digit below i is 9; carry[NDIGITS] flags all-9s.
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
      logic [3:0] cur;
      logic [3:0] ld;
      assign cur       = count_reg[4*gi +: 4];
      assign ld        = load_value[4*gi +: 4];
      assign digit[gi] = cur;
      assign carry[gi+1] = carry[gi] & (cur == 4'd9);
      assign inc_value[4*gi +: 4]  = !carry[gi] ? cur : ((cur == 4'd9) ? 4'd0 : cur + 4'd1);
      assign load_clean[4*gi +: 4] = (ld > 4'd9) ? 4'd0 : ld;
      // upper_zero[i]: this digit and every more significant one is zero
      if (gi == NDIGITS - 1) begin : g_top
        assign upper_zero[gi] = (cur == 4'd0);
      end else begin : g_low
        assign upper_zero[gi] = (cur == 4'd0) & upper_zero[gi+1];
      end
    end
  endgenerate

  always_comb begin
    count_next    = count_reg;
    overflow_next = 1'b0;
    if (clr) begin
      count_next = '0;
    end else if (load) begin
      count_next = load_clean;
    end else if (inc) begin
      count_next    = inc_value;
      overflow_next = carry[NDIGITS];
    end
  end

  always_comb begin
    index_next = index_reg;
    if (prescale_reg == PRE_LAST) begin
      index_next = (index_reg == IDX_LAST) ? '0 : index_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      prescale_reg <= '0;
      index_reg    <= '0;
      digit_en_reg <= NDIGITS'(1);
    end else begin
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      prescale_reg <= (prescale_reg == PRE_LAST) ? '0 : prescale_reg + 1'b1;
      index_reg    <= index_next;
      digit_en_reg <= NDIGITS'(1) << index_next;
    end
  end

  // Digit 0 is never blanked so a zero count still shows a single "0".
  assign blank    = (BLANK_LZ != 0) && (index_reg != '0) && upper_zero[index_reg];
  assign data     = blank ? 4'hF : digit[index_reg];
  assign count    = count_reg;
  assign overflow = overflow_reg;
  assign digit_en = digit_en_reg;

endmodule
